rank_filter: RTL and testbench

RANK_FILTER -- requirements
Module: rank_filter

---
 rtl/rank_filter_pkg.sv | 20 ++
 rtl/rank_filter_cmp_swap.sv | 21 ++
 rtl/rank_filter.sv | 177 +++++++++++++++++
 tb/tb_rank_filter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rank_filter_pkg.sv
// Shared definitions for the rank filter: FSM state encoding and rank helpers.
package rank_filter_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default geometry, for instantiating blocks and benches
  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_N      = 9;

  // Rank index of the median for an odd window size n
  function automatic int unsigned MEDIAN_RANK(input int unsigned n);
    return (n - 1) / 2;
  endfunction

endpackage

// File: rtl/rank_filter_cmp_swap.sv
// Unsigned compare-exchange element.
// Ports:
//   a, b   : input operands
//   lo, hi : smaller / larger operand; equal operands pass through unswapped
module cmp_swap #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);

  logic w_swap;

  // Swap only on strict inequality so ties keep their positions
  assign w_swap = (b < a);
  assign lo     = w_swap ? b : a;
  assign hi     = w_swap ? a : b;

endmodule

// File: rtl/rank_filter.sv
// Rank-order filter: captures an N-sample window, sorts it with odd-even
// transposition (one layer per clock), and returns the sample at the requested
// rank through a valid/ready output handshake.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : window handshake (in_ready high only when idle)
//   in_window          : N flattened samples, sample k at [k*DATA_W +: DATA_W]
//   rank_sel           : requested rank (0 = min, N-1 = max), clamped to N-1
//   out_valid/out_ready: result handshake
//   out_data           : selected-rank value, 0 while out_valid is low
//   busy               : high whenever the controller is not idle
module rank_filter
  import rank_filter_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N      = 9,
  parameter int unsigned RANK_W = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   in_window,
  input  logic [RANK_W-1:0]     rank_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  busy
);

  localparam int unsigned PH_W  = $clog2(N);
  localparam int unsigned NPAIR = N / 2;

  // Controller state and registered outputs
  state_e              r_state;
  state_e              w_state_nx;
  logic                r_in_ready;
  logic                w_in_ready_nx;
  logic                r_busy;
  logic                w_busy_nx;
  logic                r_out_valid;
  logic                w_out_valid_nx;
  logic [DATA_W-1:0]   r_out_data;
  logic [DATA_W-1:0]   w_out_data_nx;

  // Datapath
  logic [PH_W-1:0]     r_phase;
  logic [RANK_W-1:0]   r_rank;
  logic [DATA_W-1:0]   r_win  [N];
  logic [DATA_W-1:0]   w_even [N];
  logic [DATA_W-1:0]   w_odd  [N];
  logic [DATA_W-1:0]   w_next [N];
  logic                w_capture;
  logic                w_last_phase;

  assign w_last_phase = (r_phase == PH_W'(N - 1));

  // Even layer: pairs (0,1),(2,3),...; the top sample has no partner
  for (genvar g = 0; g < NPAIR; g++) begin : g_even
    cmp_swap #(.DATA_W(DATA_W)) u_cs (
      .a  (r_win[2*g]),
      .b  (r_win[2*g+1]),
      .lo (w_even[2*g]),
      .hi (w_even[2*g+1])
    );
  end
  assign w_even[N-1] = r_win[N-1];

  // Odd layer: pairs (1,2),(3,4),...; sample 0 has no partner
  assign w_odd[0] = r_win[0];
  for (genvar g = 0; g < NPAIR; g++) begin : g_odd
    cmp_swap #(.DATA_W(DATA_W)) u_cs (
      .a  (r_win[2*g+1]),
      .b  (r_win[2*g+2]),
      .lo (w_odd[2*g+1]),
      .hi (w_odd[2*g+2])
    );
  end

  // Phase parity picks which layer is applied this cycle
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_next[k] = r_phase[0] ? w_odd[k] : w_even[k];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_in_ready  <= w_in_ready_nx;
      r_busy      <= w_busy_nx;
      r_out_valid <= w_out_valid_nx;
      r_out_data  <= w_out_data_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nx     = r_state;
    w_in_ready_nx  = 1'b0;
    w_busy_nx      = 1'b1;
    w_out_valid_nx = 1'b0;
    w_out_data_nx  = '0;
    w_capture      = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready_nx = 1'b1;
        w_busy_nx     = 1'b0;
        if (in_valid) begin
          w_capture     = 1'b1;
          w_state_nx    = SORT;
          w_in_ready_nx = 1'b0;
          w_busy_nx     = 1'b1;
        end
      end
      SORT: begin
        if (w_last_phase) begin
          // Result is taken from the final layer's output as it is written
          w_state_nx     = DONE;
          w_out_valid_nx = 1'b1;
          w_out_data_nx  = w_next[r_rank];
        end
      end
      DONE: begin
        w_out_valid_nx = 1'b1;
        w_out_data_nx  = r_out_data;
        if (out_ready) begin
          w_state_nx     = IDLE;
          w_out_valid_nx = 1'b0;
          w_out_data_nx  = '0;
          w_in_ready_nx  = 1'b1;
          w_busy_nx      = 1'b0;
        end
      end
      default: begin
        w_state_nx    = IDLE;
        w_in_ready_nx = 1'b1;
        w_busy_nx     = 1'b0;
      end
    endcase
  end

  // Window capture, per-phase sort update and phase counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        r_win[k] <= '0;
      end
      r_rank  <= '0;
      r_phase <= '0;
    end else if (w_capture) begin
      for (int k = 0; k < N; k++) begin
        r_win[k] <= in_window[k*DATA_W +: DATA_W];
      end
      r_rank  <= (rank_sel > RANK_W'(N - 1)) ? RANK_W'(N - 1) : rank_sel;
      r_phase <= '0;
    end else if (r_state == SORT) begin
      for (int k = 0; k < N; k++) begin
        r_win[k] <= w_next[k];
      end
      r_phase <= w_last_phase ? '0 : r_phase + PH_W'(1);
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_rank_filter.sv
// Directed and randomized checks of rank_filter with N=9, DATA_W=8.
module tb_rank_filter;
  import rank_filter_pkg::*;

  localparam int DW = 8;
  localparam int NN = 9;
  localparam int RW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [NN*DW-1:0] in_window;
  logic [RW-1:0]   rank_sel;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  rank_filter #(.DATA_W(DW), .N(NN), .RANK_W(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_window (in_window),
    .rank_sel  (rank_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bubble sort of the unpacked window, clamped rank lookup
  function automatic logic [7:0] model_rank(input logic [NN*DW-1:0] w, input int r);
    logic [7:0] a [NN];
    logic [7:0] t;
    int rr;
    for (int k = 0; k < NN; k++) a[k] = w[k*DW +: DW];
    for (int i = 0; i < NN - 1; i++)
      for (int j = 0; j < NN - 1 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    rr = (r > NN - 1) ? NN - 1 : r;
    return a[rr];
  endfunction

  // One full transaction with latency and result checks
  task automatic do_txn(input string tag, input logic [NN*DW-1:0] win,
                        input logic [RW-1:0] rk, input logic [7:0] exp);
    int g;
    int lat;
    g = 0;
    while (!in_ready && g < 50) begin tick; g++; end
    in_window = win; rank_sel = rk; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_inrdy"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin tick; lat++; end
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, "_drop"}, out_valid, 0);
    chk({tag, "_zero"}, out_data, 0);
  endtask

  // Windows written MSB-first, so the last listed byte is sample 0
  logic [NN*DW-1:0] w_desc;   // samples 9,8,...,1
  logic [NN*DW-1:0] w_asc;    // samples 1,2,...,9
  logic [NN*DW-1:0] w_alt;    // 0,255,0,255,0,255,0,255,128
  logic [NN*DW-1:0] w_eq;     // all 0x3C
  logic [NN*DW-1:0] rwin;
  logic [RW-1:0]    rrank;
  logic [7:0]       exp8;
  int               lat, guard, cap, prev_cap, flag;
  bit               seen, done;

  initial begin
    w_desc = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    w_asc  = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    w_alt  = {8'd128, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0};
    w_eq   = {NN{8'h3C}};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_window = '0; rank_sel = '0;
    repeat (3) tick;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);

    // Release and present a window immediately: captured on the first edge
    rst_n = 1'b1;
    chk("rel_in_ready", in_ready, 1);
    do_txn("desc_med", w_desc, RW'(MEDIAN_RANK(NN)), 8'd5);

    do_txn("alt_r0", w_alt, 4'd0, 8'd0);
    do_txn("alt_r4", w_alt, 4'd4, 8'd128);
    do_txn("alt_r8", w_alt, 4'd8, 8'd255);
    do_txn("eq_clamp", w_eq, 4'd15, 8'h3C);
    do_txn("asc_clamp", w_asc, 4'd15, 8'd9);
    do_txn("desc_r1", w_desc, 4'd1, 8'd2);

    // Backpressure: garbage in_valid pulses during SORT and DONE are ignored
    in_window = w_desc; rank_sel = 4'd0; in_valid = 1'b1;
    tick;
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid  = lat[0];
      in_window = {NN{8'($urandom_range(0, 255))}};
      rank_sel  = 4'd8;
      tick; lat++;
    end
    chk("bp_lat", lat, 9);
    for (int i = 0; i < 20; i++) begin
      in_valid  = i[0];
      in_window = {NN{8'($urandom_range(0, 255))}};
      tick;
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 1);
      chk("bp_inrdy", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("bp_drop", out_valid, 0);
    chk("bp_idle_inrdy", in_ready, 1);
    chk("bp_idle_busy", busy, 0);
    tick;
    chk("bp_no_repeat", out_valid, 0);

    // Reset in the middle of sorting discards the window
    in_window = w_desc; rank_sel = 4'd4; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (3) tick;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    tick;
    rst_n = 1'b1;
    flag = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (out_valid) flag = 1;
    end
    chk("mid_rst_no_out", flag, 0);
    chk("mid_rst_inrdy", in_ready, 1);
    do_txn("post_rst", w_asc, 4'd4, 8'd5);

    // Random windows and ranks against the reference model
    prev_cap = 0;
    for (int t = 0; t < 1000; t++) begin
      for (int k = 0; k < NN; k++)
        rwin[k*DW +: DW] = 8'($urandom_range(0, (t % 3 == 0) ? 3 : 255));
      rrank = RW'($urandom_range(0, 15));
      exp8  = model_rank(rwin, int'(rrank));
      in_window = rwin; rank_sel = rrank; in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 100) begin tick; guard++; end
      chk("rnd_ready", in_ready, 1);
      tick;
      cap = cyc;
      in_valid  = 1'b0;
      in_window = {NN{8'($urandom_range(0, 255))}};
      rank_sel  = RW'($urandom_range(0, 15));
      if (t > 0 && t <= 50) chk("rnd_interval", cap - prev_cap, 11);
      prev_cap = cap;
      lat = 0; seen = 1'b0; done = 1'b0;
      while (!done && lat < 300) begin
        out_ready = (t < 50) ? 1'b1 : 1'($urandom_range(0, 1));
        if (lat == 0) chk("rnd_zero_idle", out_data, 0);
        if (out_valid) begin
          if (!seen) begin
            seen = 1'b1;
            chk("rnd_latency", lat, 9);
          end
          if (out_ready) begin
            chk("rnd_data", out_data, exp8);
            done = 1'b1;
          end
        end
        tick; lat++;
      end
      out_ready = 1'b0;
      chk("rnd_done", done, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
